// File: rtl/pdm_decimator.sv
// rtl/pdm_decimator.sv - 2nd-order CIC decimator turning a PDM bit stream into 8-bit unsigned PCM samples
module pdm_decimator #(
    parameter int DECIM = 64,
    parameter int AW    = 2 * $clog2(DECIM) + 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       pdm_bit,
    input  logic       pdm_valid,
    output logic [7:0] pcm_data,
    output logic       pcm_valid,
    input  logic       pcm_ready,
    output logic       overrun
);

    localparam int            LD      = $clog2(DECIM);
    localparam logic [AW-1:0] SAT_MAX = AW'(DECIM * DECIM - 1);
    localparam logic [LD-1:0] LAST    = LD'(DECIM - 1);

    logic [LD-1:0] count;
    logic [AW-1:0] i1, i2, d1, d2;
    logic          close_d;

    logic          accept, close;
    logic [AW-1:0] i1_new, c1, c2, c2_sat;
    logic [7:0]    pcm_next;

    always_comb begin
        accept   = enable & pdm_valid;
        close    = accept && (count == LAST);
        i1_new   = i1 + AW'(pdm_bit);
        c1       = i2 - d1;
        c2       = c1 - d2;
        c2_sat   = (c2 > SAT_MAX) ? SAT_MAX : c2;
        // Top 8 bits of the 2*log2(DECIM)-bit full-scale range; zero-filled below bit 0 for small DECIM
        pcm_next = 8'(({c2_sat, 8'd0}) >> (2 * LD));
    end

    // Integrators and window counter run at the accepted-bit rate
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count   <= '0;
            i1      <= '0;
            i2      <= '0;
            close_d <= 1'b0;
        end else begin
            close_d <= close;
            if (accept) begin
                i1    <= i1_new;
                i2    <= i2 + i1_new;
                count <= count + LD'(1);
            end
        end
    end

    // Combs evaluate from the integrator value frozen at window close; d2 holds the previous c1
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            d1        <= '0;
            d2        <= '0;
            pcm_data  <= 8'h00;
            pcm_valid <= 1'b0;
            overrun   <= 1'b0;
        end else if (close_d) begin
            d1        <= i2;
            d2        <= c1;
            pcm_data  <= pcm_next;
            pcm_valid <= 1'b1;
            if (pcm_valid && !pcm_ready)
                overrun <= 1'b1;
        end else if (pcm_valid && pcm_ready) begin
            pcm_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_pdm_decimator.sv
// tb/tb_pdm_decimator.sv - self-checking bench for pdm_decimator against a window-sum CIC model
module tb_pdm_decimator;

    localparam int DECIM = 64;
    localparam int AW    = 14;

    logic       clk = 1'b0;
    logic       reset, enable, pdm_bit, pdm_valid, pcm_ready;
    logic [7:0] pcm_data;
    logic       pcm_valid, overrun;

    pdm_decimator #(.DECIM(DECIM)) dut (
        .clk(clk), .reset(reset), .enable(enable), .pdm_bit(pdm_bit),
        .pdm_valid(pdm_valid), .pcm_data(pcm_data), .pcm_valid(pcm_valid),
        .pcm_ready(pcm_ready), .overrun(overrun)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Model: unbounded running sums; each window's CIC output is the second difference of
    // the double sum sampled at window boundaries, reduced modulo 2^AW, saturated, scaled.
    longint s1, s2, prev_i2, prev_c1;
    int     n_acc, pend_data, exp_data;
    logic   close_pend, exp_valid, exp_ovr;

    function automatic int quant(input longint c2);
        longint r;
        r = c2 & ((longint'(1) << AW) - 1);
        if (r > DECIM * DECIM - 1) r = DECIM * DECIM - 1;
        return int'((r * 256) / (DECIM * DECIM));
    endfunction

    always @(posedge clk or posedge reset) begin
        longint c1, c2;
        if (reset) begin
            s1 = 0; s2 = 0; prev_i2 = 0; prev_c1 = 0; n_acc = 0;
            close_pend = 0; pend_data = 0; exp_valid = 0; exp_data = 0; exp_ovr = 0;
        end else begin
            if (close_pend) begin
                if (exp_valid && !pcm_ready) exp_ovr = 1;
                exp_valid = 1;
                exp_data  = pend_data;
            end else if (exp_valid && pcm_ready) begin
                exp_valid = 0;
            end
            close_pend = 0;
            if (enable && pdm_valid) begin
                s1 = s1 + longint'(pdm_bit);
                s2 = s2 + s1;
                n_acc++;
                if (n_acc % DECIM == 0) begin
                    c1 = s2 - prev_i2;
                    c2 = c1 - prev_c1;
                    prev_i2 = s2;
                    prev_c1 = c1;
                    pend_data  = quant(c2);
                    close_pend = 1;
                end
            end
        end
    end

    int vectors = 0;
    int errors  = 0;
    int hs_d[$];
    int hs_t[$];
    int qa[$];

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        if (!reset && pcm_valid && pcm_ready) begin
            hs_d.push_back(int'(pcm_data));
            hs_t.push_back(cyc);
        end
        @(posedge clk);
        #1;
        vectors++;
        if (pcm_valid !== exp_valid || overrun !== exp_ovr ||
            (exp_valid && pcm_data !== 8'(exp_data))) begin
            errors++;
            $display("FAIL model_cycle: got valid=%0b data=%0d ovr=%0b, expected valid=%0b data=%0d ovr=%0b (t=%0t)",
                     pcm_valid, pcm_data, overrun, exp_valid, exp_data, exp_ovr, $time);
        end
    endtask

    task automatic send(input logic b, input logic en, input int gap);
        pdm_bit = b; enable = en; pdm_valid = 1'b1;
        tick();
        pdm_valid = 1'b0;
        repeat (gap) tick();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        hs_d.delete();
        hs_t.delete();
    endtask

    function automatic int hs_at(input int i);
        return (i < hs_d.size()) ? hs_d[i] : -1;
    endfunction

    function automatic int ht_at(input int i);
        return (i < hs_t.size()) ? hs_t[i] : -1;
    endfunction

    logic bits [256];

    initial begin
        int cE, lat, p;
        reset = 1'b1; enable = 1'b0; pdm_bit = 1'b0; pdm_valid = 1'b0; pcm_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset_data", pcm_data, 0);
        check("reset_valid", pcm_valid, 0);
        check("reset_overrun", overrun, 0);

        // Constant ones, one bit every 4 clk: 0x82 warm-up, then full scale every 256 clk
        do_reset();
        for (int i = 0; i < 4 * DECIM; i++) send(1'b1, 1'b1, 3);
        repeat (4) tick();
        check("ones_count", hs_d.size(), 4);
        check("ones_out0", hs_at(0), 8'h82);
        check("ones_out1", hs_at(1), 8'hFF);
        check("ones_out2", hs_at(2), 8'hFF);
        check("ones_out3", hs_at(3), 8'hFF);
        check("ones_period", ht_at(3) - ht_at(2), 256);

        // Constant zeros
        do_reset();
        for (int i = 0; i < 3 * DECIM; i++) send(1'b0, 1'b1, 0);
        repeat (4) tick();
        check("zeros_count", hs_d.size(), 3);
        foreach (hs_d[i]) check("zeros_out", hs_d[i], 0);

        // Alternating 1,0 with irregular gaps: 0x42 warm-up then mid scale
        do_reset();
        for (int i = 0; i < 4 * DECIM; i++) send(1'b1 ^ 1'(i), 1'b1, $urandom_range(0, 2));
        repeat (4) tick();
        check("alt_out0", hs_at(0), 8'h42);
        check("alt_out1", hs_at(1), 8'h80);
        check("alt_out3", hs_at(3), 8'h80);

        // Consumer stalled across two window closes
        do_reset();
        pcm_ready = 1'b0;
        for (int i = 0; i < 2 * DECIM; i++) send(1'b1, 1'b1, 1);
        repeat (3) tick();
        check("ovr_flag", overrun, 1);
        check("ovr_valid", pcm_valid, 1);
        check("ovr_data", pcm_data, 8'hFF);
        pcm_ready = 1'b1;
        tick();
        check("ovr_drop_valid", pcm_valid, 0);
        check("ovr_sticky", overrun, 1);

        // Asynchronous reset with a held sample and 30 bits into the next window
        do_reset();
        pcm_ready = 1'b0;
        for (int i = 0; i < DECIM + 30; i++) send(1'b1, 1'b1, 1);
        check("pre_reset_valid", pcm_valid, 1);
        @(posedge clk);
        #3 reset = 1'b1;
        #1;
        check("async_reset_valid", pcm_valid, 0);
        check("async_reset_data", pcm_data, 0);
        check("async_reset_overrun", overrun, 0);
        #3 reset = 1'b0;
        pcm_ready = 1'b1;
        for (int i = 0; i < DECIM - 1; i++) send(1'b1, 1'b1, 2);
        pdm_bit = 1'b1; pdm_valid = 1'b1;
        tick();
        cE = cyc;
        pdm_valid = 1'b0;
        for (int k = 0; k < 10 && !pcm_valid; k++) tick();
        lat = pcm_valid ? (cyc - cE + 1) : -1;
        check("post_reset_latency", lat, 2);
        repeat (3) tick();

        // Disabled pulses mid-window must not change the output sequence
        foreach (bits[i]) bits[i] = 1'($urandom);
        do_reset();
        for (int i = 0; i < 4 * DECIM; i++) send(bits[i], 1'b1, $urandom_range(0, 2));
        repeat (4) tick();
        qa = hs_d;
        do_reset();
        for (int i = 0; i < 100; i++) send(bits[i], 1'b1, $urandom_range(0, 2));
        for (int i = 0; i < 100; i++) send(1'($urandom), 1'b0, $urandom_range(0, 2));
        for (int i = 100; i < 4 * DECIM; i++) send(bits[i], 1'b1, $urandom_range(0, 2));
        repeat (4) tick();
        check("gate_count", hs_d.size(), qa.size());
        foreach (qa[i]) check("gate_sample", hs_at(i), qa[i]);

        // Randomized traffic: density, enable, backpressure and one reset pulse
        do_reset();
        p = 50;
        for (int i = 0; i < 2500; i++) begin
            if (i % 400 == 0) p = $urandom_range(0, 100);
            if (i == 1200) begin
                reset = 1'b1;
                tick();
                reset = 1'b0;
            end
            enable    = ($urandom_range(0, 15) != 0);
            pdm_valid = ($urandom_range(0, 2) == 0);
            pdm_bit   = ($urandom_range(0, 99) < p);
            pcm_ready = ($urandom_range(0, 3) != 0);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
